// File: rtl/fetch_unit_if.sv
// Instruction-memory port of the fetch unit: single-outstanding req/rvalid.
interface fetch_unit_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// IF-stage fetch engine: owns the PC, fetches one instruction at a time from
// instruction memory and presents it (or a NOP bubble) to the IF/ID register.
// Optional macro FETCH_BYPASS_EN: forward the memory response straight onto
// instrF in the WAIT cycle when not stalled, skipping the READY cycle.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stallF,
  input  logic                pcsrcE,
  input  logic [31:0]         pctargetE,
  fetch_unit_if.master        imem,
  output logic [31:0]         instrF,
  output logic [31:0]         pcF,
  output logic [31:0]         pcplus4F,
  output logic                fetch_busy
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_ibuf;

  state_t          w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_ibuf_nxt;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_instr;
  logic            w_busy;

  assign w_pc_plus4 = XLEN'(r_pc + XLEN'(4));

  // State, PC and instruction buffer registers; synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ISSUE;
      r_pc    <= RESET_PC;
      r_ibuf  <= NOP_INSTR;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ibuf  <= w_ibuf_nxt;
    end
  end

  // Next-state, next-PC and presented instruction.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ibuf_nxt  = r_ibuf;
    w_instr     = NOP_INSTR;
    w_busy      = 1'b1;

    case (r_state)
      ISSUE: begin
        // Request leaves this cycle; a redirect must drop its response later.
        if (pcsrcE) begin
          w_pc_nxt    = pctargetE;
          w_state_nxt = FLUSH;
        end else begin
          w_state_nxt = WAIT;
        end
      end

      WAIT: begin
        if (pcsrcE) begin
          w_pc_nxt    = pctargetE;
          // Response arriving now is the stale one; otherwise still in flight.
          w_state_nxt = imem.imem_rvalid ? ISSUE : FLUSH;
        end else if (imem.imem_rvalid) begin
`ifdef FETCH_BYPASS_EN
          if (!stallF) begin
            w_instr     = imem.imem_rdata;
            w_busy      = 1'b0;
            w_pc_nxt    = w_pc_plus4;
            w_state_nxt = ISSUE;
          end else begin
            w_ibuf_nxt  = imem.imem_rdata;
            w_state_nxt = READY;
          end
`else
          w_ibuf_nxt  = imem.imem_rdata;
          w_state_nxt = READY;
`endif
        end
      end

      READY: begin
        w_instr = r_ibuf;
        w_busy  = 1'b0;
        // Redirect wins over a stall; the buffered instruction is dropped.
        if (pcsrcE) begin
          w_pc_nxt    = pctargetE;
          w_state_nxt = ISSUE;
        end else if (!stallF) begin
          w_pc_nxt    = w_pc_plus4;
          w_state_nxt = ISSUE;
        end
      end

      FLUSH: begin
        // Latest redirect wins while waiting out the stale response.
        if (pcsrcE) begin
          w_pc_nxt = pctargetE;
        end
        if (imem.imem_rvalid) begin
          w_state_nxt = ISSUE;
        end
      end

      default: begin
        w_state_nxt = ISSUE;
      end
    endcase
  end

  assign imem.imem_req  = (r_state == ISSUE);
  assign imem.imem_addr = r_pc;
  assign pcF            = r_pc;
  assign pcplus4F       = w_pc_plus4;
  assign instrF         = w_instr;
  assign fetch_busy     = w_busy;

endmodule
